// File: rtl/cache_pkg.sv
// Shared definitions for the store-filled, write-allocate 2-way data cache.
// Holds the default geometry, the per-line storage layout and the address split.
// Tag keeps the byte-offset bits, so an entry matches only its exact store address.
package cache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int SET_BITS   = 6;
    localparam int WAYS       = 2;
    localparam int SETS       = 2 ** SET_BITS;
    // Upper address bits above the index plus the two byte-offset bits.
    localparam int TAG_WIDTH  = ADDR_WIDTH - SET_BITS;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [SET_BITS-1:0]   index_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        data_t data;
    } line_t;

    function automatic index_t addr_index(input addr_t a);
        return a[SET_BITS+1:2];
    endfunction

    function automatic tag_t addr_tag(input addr_t a);
        return {a[ADDR_WIDTH-1:SET_BITS+2], a[1:0]};
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// Lookup/store bundle between the memory stage (master) and the data cache (slave).
// addr/wdata/we are driven by the memory stage; hit/rdata come back combinationally.
// No handshake: one lookup and at most one store per cycle, never stalled.
interface data_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  hit;

    modport master (output addr, output wdata, output we, input rdata, input hit);
    modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/data_cache.sv
// 2-way set-associative data cache, filled only by write-through stores.
// Latency: lookup (hit/rdata) is combinational from addr; a store is visible the cycle after its edge.
// Backpressure: none -- accepts one store per cycle and never stalls.
// Ports: clk, rst_n (synchronous, active low), bus (data_cache_if.slave: addr, wdata, we -> rdata, hit).
// Geometry overrides must match cache_pkg, which fixes the line layout and address split.
module data_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int SET_BITS   = cache_pkg::SET_BITS,
    parameter int WAYS       = cache_pkg::WAYS
) (
    input  logic          clk,
    input  logic          rst_n,
    data_cache_if.slave   bus
);

    localparam int NUM_SETS = 2 ** SET_BITS;

    line_t lines [NUM_SETS][WAYS];
    // Per set: the way to replace next once both ways are valid.
    logic  lru   [NUM_SETS];

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;
    index_t                idx;
    tag_t                  tag;
    logic [WAYS-1:0]       way_hit;
    logic                  hit;
    logic                  hit_way;
    logic                  victim;
    line_t                 new_line;

    assign addr = bus.addr;
    assign idx  = addr_index(addr);
    assign tag  = addr_tag(addr);

    always_comb begin
        way_hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = lines[idx][w].valid && (lines[idx][w].tag == tag);
        end
    end

    // Stores to an existing tag update in place, so at most one way matches
    // and an OR of the gated data words is a valid mux (zero on miss).
    always_comb begin
        rdata = '0;
        for (int w = 0; w < WAYS; w++) begin
            rdata = rdata | (lines[idx][w].data & {DATA_WIDTH{way_hit[w]}});
        end
    end

    assign hit     = |way_hit;
    assign hit_way = way_hit[1];

    // Fill empty ways in order before displacing anything; only then consult LRU.
    always_comb begin
        if (!lines[idx][0].valid) begin
            victim = 1'b0;
        end else if (!lines[idx][1].valid) begin
            victim = 1'b1;
        end else begin
            victim = lru[idx];
        end
    end

    always_comb begin
        new_line       = '0;
        new_line.valid = 1'b1;
        new_line.tag   = tag;
        new_line.data  = bus.wdata;
    end

    assign bus.hit   = hit;
    assign bus.rdata = rdata;

    // Data fields are deliberately left out of reset; valid gates them everywhere.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                lru[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    lines[s][w].valid <= 1'b0;
                end
            end
        end else if (bus.we) begin
            if (hit) begin
                lines[idx][hit_way].data <= bus.wdata;
                lru[idx]                 <= ~hit_way;
            end else begin
                lines[idx][victim] <= new_line;
                lru[idx]           <= ~victim;
            end
        end else if (hit) begin
            lru[idx] <= ~hit_way;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_cache_if bus();

    data_cache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per set, resident addresses ordered least- to most-recently used.
    int unsigned  set_q [64][$];
    logic [31:0]  mem   [int unsigned];

    function automatic int set_of(input int unsigned a);
        return int'((a >> 2) & 32'd63);
    endfunction

    function automatic int find(input int unsigned a);
        int s;
        s = set_of(a);
        foreach (set_q[s][i]) begin
            if (set_q[s][i] == a) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 64; s++) set_q[s].delete();
        mem.delete();
    endtask

    task automatic model_touch(input int unsigned a);
        int s;
        int i;
        s = set_of(a);
        i = find(a);
        if (i >= 0) begin
            set_q[s].delete(i);
            set_q[s].push_back(a);
        end
    endtask

    task automatic model_write(input int unsigned a, input logic [31:0] d);
        int s;
        int unsigned v;
        s = set_of(a);
        if (find(a) >= 0) begin
            model_touch(a);
        end else begin
            if (set_q[s].size() == 2) begin
                v = set_q[s].pop_front();
                mem.delete(v);
            end
            set_q[s].push_back(a);
        end
        mem[a] = d;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, compare just after, advance the model at posedge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic r, input bit use_c, input logic c_hit,
                        input logic [31:0] c_data, input string name);
        logic        eh;
        logic [31:0] ed;
        @(negedge clk);
        rst_n     = r;
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = w;
        #1;
        eh = (find(a) >= 0);
        ed = eh ? mem[a] : 32'h0;
        check({name, "_hit"},   32'(bus.hit), 32'(eh));
        check({name, "_rdata"}, bus.rdata,    ed);
        if (use_c) begin
            check({name, "_hit_const"},   32'(bus.hit), 32'(c_hit));
            check({name, "_rdata_const"}, bus.rdata,    c_data);
        end
        @(posedge clk);
        if (!r) begin
            model_clear();
        end else if (w) begin
            model_write(a, d);
        end else if (eh) begin
            model_touch(a);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic c_hit, input logic [31:0] c_data,
                      input string name);
        step(a, 32'h0, 1'b0, 1'b1, 1'b1, c_hit, c_data, name);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic c_hit,
                      input logic [31:0] c_data, input string name);
        step(a, d, 1'b1, 1'b1, 1'b1, c_hit, c_data, name);
    endtask

    initial begin
        int unsigned resident [$];
        logic [31:0] ra;
        logic [31:0] rdv;
        logic        rw;

        rst_n     = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        repeat (3) @(posedge clk);
        model_clear();

        rd(32'h0001_0000, 1'b0, 32'h0, "reset_miss");

        // First store: miss during its own cycle, visible on the next.
        wr(32'h0001_0000, 32'hDEAD_BEEF, 1'b0, 32'h0,         "first_write");
        rd(32'h0001_0000, 1'b1, 32'hDEAD_BEEF,                "first_read");

        // Same set, two ways, then eviction of the least recently used entry.
        wr(32'h0001_0000, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, "ovw_a");
        wr(32'h0001_0100, 32'h2222_2222, 1'b0, 32'h0,         "fill_b");
        rd(32'h0001_0000, 1'b1, 32'h1111_1111,                "hit_a");
        rd(32'h0001_0100, 1'b1, 32'h2222_2222,                "hit_b");
        rd(32'h0001_0000, 1'b1, 32'h1111_1111,                "touch_a");
        wr(32'h0001_0200, 32'h3333_3333, 1'b0, 32'h0,         "fill_c");
        rd(32'h0001_0100, 1'b0, 32'h0,                        "evicted_b");
        rd(32'h0001_0000, 1'b1, 32'h1111_1111,                "kept_a");
        rd(32'h0001_0200, 1'b1, 32'h3333_3333,                "kept_c");

        // Repeated store to one address stays in one way; the neighbour survives.
        wr(32'h0001_0000, 32'hAAAA_5555, 1'b1, 32'h1111_1111, "ovw1");
        wr(32'h0001_0000, 32'h1234_5678, 1'b1, 32'hAAAA_5555, "ovw2");
        rd(32'h0001_0000, 1'b1, 32'h1234_5678,                "ovw_read");
        rd(32'h0001_0200, 1'b1, 32'h3333_3333,                "one_way_used");

        // Byte offset is part of the tag.
        wr(32'h0001_0001, 32'h5A5A_5A5A, 1'b0, 32'h0,         "byte_write");
        rd(32'h0001_0000, 1'b0, 32'h0,                        "byte_other_miss");
        rd(32'h0001_0001, 1'b1, 32'h5A5A_5A5A,                "byte_exact_hit");

        // Random traffic over 4 sets x 4 tags with occasional odd byte offsets.
        for (int n = 0; n < 1500; n++) begin
            ra = 32'h0001_0000
               | (32'($urandom_range(0, 3)) << 12)
               | (32'($urandom_range(0, 3)) << 2)
               | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            rdv = $urandom;
            rw  = ($urandom_range(0, 9) < 4);
            step(ra, rdv, rw, 1'b1, 1'b0, 1'b0, 32'h0, "rand");
        end

        // Fill a few more sets, then one reset clock with a store that must be dropped.
        wr(32'h0002_0040, 32'hCAFE_0001, 1'b0, 32'h0, "pre_rst_w0");
        wr(32'h0002_0080, 32'hCAFE_0002, 1'b0, 32'h0, "pre_rst_w1");
        for (int s = 0; s < 64; s++) begin
            foreach (set_q[s][i]) resident.push_back(set_q[s][i]);
        end
        step(32'h0003_0044, 32'hBAD0_BAD0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "rst_cycle");
        foreach (resident[i]) begin
            rd(resident[i], 1'b0, 32'h0, "post_rst");
        end
        rd(32'h0003_0044, 1'b0, 32'h0, "rst_write_ignored");

        // Cache is usable again after reset.
        wr(32'h0003_0044, 32'h0BAD_F00D, 1'b0, 32'h0, "post_rst_write");
        rd(32'h0003_0044, 1'b1, 32'h0BAD_F00D,        "post_rst_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Small 2-way set-associative, write-allocate cache for data words.
- Sits beside the data memory in the CPU's memory stage.
- Lookup is combinational: a hit returns the cached word in the same cycle, so the parent selects `rdata` over its RAM read.
- It has no refill port. Entries are filled only by stores (`we`), and each store also goes to main memory in the parent (write-through).

Parameters:
- ADDR_WIDTH, 32, width of `addr`.
- DATA_WIDTH, 32, width of `wdata` and `rdata`.
- SET_BITS, 6, index bits; number of sets = 2**SET_BITS = 64.
- WAYS, 2, associativity; fixed at 2, and the LRU scheme depends on it.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- addr, input, ADDR_WIDTH, byte address for lookup and write.
- wdata, input, DATA_WIDTH, word to store.
- we, input, 1, write enable; sampled at the rising edge of `clk`.
- rdata, output, DATA_WIDTH, data from the hitting way (combinational).
- hit, output, 1, lookup hit (combinational).

Behaviour:
- Reset is synchronous and active-low: one clock with one reset, `rst_n` low at a rising edge of `clk` clears all valid bits and all LRU bits. Data arrays are not cleared. While reset is asserted, no write takes effect.
- Address split:
  - index = addr[SET_BITS+1:2].
  - tag = {addr[ADDR_WIDTH-1:SET_BITS+2], addr[1:0]}.
  - Byte-offset bits are part of the tag, so an entry matches only the exact address it was written with.
- Each line holds: valid, tag, DATA_WIDTH data. Each set holds one LRU bit naming the way to replace next.
- Lookup is purely combinational from `addr`, with zero-cycle latency:
  - hit = OR over ways of (valid && tag match).
  - rdata = data of the matching way.
  - rdata = 0 when `hit` = 0.
  - Both ways can never match at once, because a write to an existing tag overwrites in place.
- Lookup is independent of `we`. In a write cycle, `hit` and `rdata` show the state before the write.
- Write at the rising edge with `we` = 1 and `rst_n` = 1:
  - Tag hit in way w: overwrite the data of way w; set LRU to 1-w.
  - Miss: choose the victim way = first invalid way (way 0 before way 1); if both are valid, the way named by LRU. Write valid=1, tag and data into the victim; set LRU to the other way.
  - New data is visible on `rdata`/`hit` from the cycle after the edge.
- Read hit at a rising edge (`we` = 0, `hit` = 1): set LRU to the way that did not hit.
- Miss with `we` = 0: no state change.
- The whole `wdata` word is always stored; store size is handled by the parent.
- No stalls and no handshake; one write per cycle.

Decomposition:
- Shared package `cache_pkg`: SET_BITS/WAYS defaults, a line struct {valid, tag, data}, and tag/index extraction functions.
- Single module; no sub-module needed. Arrays are implemented as flops or inferred RAM with an asynchronous read.

Test Plan:
- Reset, then `addr` = 0x0001_0000, `we` = 0 -> `hit` = 0, `rdata` = 0.
- Write 0xDEADBEEF to 0x0001_0000, then read it -> `hit` = 1, `rdata` = 0xDEADBEEF on the next cycle; in the write cycle itself `hit` = 0.
- Write 0x11111111 to 0x0001_0000 and 0x22222222 to 0x0001_0100 (same set) -> both hit. Read 0x0001_0000, then write 0x33333333 to 0x0001_0200 -> 0x0001_0100 is evicted (`hit` = 0); the other two still hit.
- Write 0xAAAA5555 to 0x0001_0000, then write 0x12345678 to the same address -> `rdata` = 0x12345678, and only one way of the set is used.
- Write to 0x0001_0001 -> a read of 0x0001_0000 misses, and a read of 0x0001_0001 hits.
- Fill several sets, assert `rst_n` = 0 for one clock -> every previously hitting address now gives `hit` = 0, `rdata` = 0. A write presented during reset is ignored.
